// File: rtl/riscv_pkg.sv
// Constants shared by the fetch, queue and decode stages.
package riscv_pkg;

  // Word address width of the program counter.
  localparam int RV_ADDR_WIDTH = 11;

  // Instruction word width.
  localparam int RV_DATA_WIDTH = 32;

  // Canonical no-op (addi x0, x0, 0); shown downstream whenever nothing is queued.
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/instr_queue_mem.sv
// Entry storage for the instruction queue: DEPTH registers of WIDTH bits,
// one synchronous write port and one asynchronous (show-ahead) read port.
// Contents are deliberately not reset; validity is tracked by the owner.
module instr_queue_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 43
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the addressed entry on an accepted push.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Zero-latency read of the head entry.
  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_queue.sv
// Fetch-to-decode instruction queue: a circular show-ahead FIFO of
// {pc, instr} pairs with flush support for branch/jump redirects.
//
// Handshakes: an item moves across a port exactly when valid && ready is
// high at a rising clock edge. in_ready depends combinationally on flush and
// rst (never on in_valid); out_valid depends only on registered state. There
// is no pass-through: a full queue refuses a push even while it pops, and an
// empty queue never forwards a push straight to the output.
module instr_queue
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = riscv_pkg::RV_ADDR_WIDTH,
  parameter int DATA_WIDTH = riscv_pkg::RV_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_WIDTH-1:0]    in_pc,
  input  logic [DATA_WIDTH-1:0]    in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_WIDTH-1:0]    out_pc,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;

  // Flush and reset both block pushes so nothing lands in storage during a
  // redirect; pop is masked by flush because the pointers are being cleared.
  assign in_ready  = (count_q < CNT_W'(DEPTH)) && !flush && !rst;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;
  assign count     = count_q;

  // Pointer and occupancy update; priority is rst, then flush, then push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  instr_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({in_pc, in_instr}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Present the head entry, or a clean NOP bubble when nothing is queued.
  always_comb begin
    out_pc    = '0;
    out_instr = DATA_WIDTH'(RV_NOP);
    if (out_valid) begin
      out_pc    = head[ENTRY_W-1:DATA_WIDTH];
      out_instr = head[DATA_WIDTH-1:0];
    end
  end

endmodule
